bp_fe_bht_gshare: RTL and testbench

- Parametrised gshare branch history table for the front end.
- Holds 2**bht_idx_width_p saturating counters of configurable width and a speculative global history register (GHR) with checkpoint/restore on redirect.
- Initialises the table with a post-reset sweep FSM.
- Returns a registered prediction one cycle after a read request, together with the GHR snapshot used, for later update and recovery.

---
 rtl/bp_fe_bht_gshare.sv | 144 ++++++++++++++
 tb/tb_bp_fe_bht_gshare.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_gshare.sv
// bp_fe_bht_gshare
//   Gshare branch history table for the front end. Holds 2**bht_idx_width_p
//   saturating counters indexed by (PC index XOR global history), plus a
//   speculative global history register (GHR) that is shifted on predicted
//   branches and restored from a checkpoint on a redirect. After reset a
//   sweep FSM writes init_ctr_p into every entry before traffic is accepted.
//
// Ports
//   clk_i, reset_n_i         clock, synchronous active-low reset
//   init_done_o              table initialised, requests accepted
//   r_v_i, r_idx_i           predict request (index)
//   predict_*_o              registered prediction, one cycle after r_v_i
//   spec_v_i, spec_taken_i   speculative GHR shift
//   w_v_i, w_idx_i,
//   w_ghist_i, w_taken_i     commit-time counter update
//   redirect_v_i,
//   redirect_ghist_i,
//   redirect_taken_i         GHR restore on misprediction
module bp_fe_bht_gshare #(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 6,
  parameter int ctr_width_p     = 2,
  parameter int init_ctr_p      = (1 << (ctr_width_p - 1)) - 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       predict_v_o,
  output logic                       predict_taken_o,
  output logic [ctr_width_p-1:0]     predict_ctr_o,
  output logic [ghist_width_p-1:0]   predict_ghist_o,
  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i,
  input  logic                       redirect_v_i,
  input  logic [ghist_width_p-1:0]   redirect_ghist_i,
  input  logic                       redirect_taken_i
);

  localparam int DEPTH = 1 << bht_idx_width_p;

  localparam logic [0:0] e_init = 1'b0;
  localparam logic [0:0] e_run  = 1'b1;

  logic [0:0]                 r_state;
  logic [bht_idx_width_p-1:0] r_sweep;
  logic [ghist_width_p-1:0]   r_ghr;
  logic [ctr_width_p-1:0]     r_mem [DEPTH];

  logic                       w_run;
  logic [bht_idx_width_p-1:0] w_rd_hash;
  logic [bht_idx_width_p-1:0] w_wr_hash;
  logic [ctr_width_p-1:0]     w_old_ctr;
  logic [ctr_width_p-1:0]     w_new_ctr;
  logic                       w_mem_we;
  logic [bht_idx_width_p-1:0] w_mem_addr;
  logic [ctr_width_p-1:0]     w_mem_data;

  assign w_run       = (r_state == e_run);
  assign init_done_o = w_run;

  // History is zero-extended into the low index bits.
  assign w_rd_hash = r_idx_i ^ bht_idx_width_p'(r_ghr);
  assign w_wr_hash = w_idx_i ^ bht_idx_width_p'(w_ghist_i);

  // Read-modify-write of the update entry within a single cycle.
  assign w_old_ctr = r_mem[w_wr_hash];

  always_comb begin
    w_new_ctr = w_old_ctr;
    if (w_taken_i) begin
      if (w_old_ctr != '1) w_new_ctr = w_old_ctr + 1'b1;
    end else begin
      if (w_old_ctr != '0) w_new_ctr = w_old_ctr - 1'b1;
    end
  end

  // Single table write port, shared by the init sweep and commit updates.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = w_wr_hash;
    w_mem_data = w_new_ctr;
    if (reset_n_i) begin
      if (!w_run) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_sweep;
        w_mem_data = ctr_width_p'(init_ctr_p);
      end else if (w_v_i) begin
        w_mem_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Init sweep FSM: one entry per cycle, then run until the next reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_init;
      r_sweep <= '0;
    end else if (!w_run) begin
      r_sweep <= r_sweep + 1'b1;
      if (r_sweep == '1) r_state <= e_run;
    end
  end

  // Speculative GHR; a redirect overrides a same-cycle speculative shift.
  // Shift-and-OR keeps the MSB-discard behaviour valid for a 1-bit GHR.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ghr <= '0;
    end else if (w_run) begin
      if (redirect_v_i)
        r_ghr <= (redirect_ghist_i << 1) | ghist_width_p'(redirect_taken_i);
      else if (spec_v_i)
        r_ghr <= (r_ghr << 1) | ghist_width_p'(spec_taken_i);
    end
  end

  // Registered prediction; the table read sees the pre-update contents.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      predict_v_o     <= 1'b0;
      predict_taken_o <= 1'b0;
      predict_ctr_o   <= '0;
      predict_ghist_o <= '0;
    end else if (w_run && r_v_i) begin
      predict_v_o     <= 1'b1;
      predict_ctr_o   <= r_mem[w_rd_hash];
      predict_taken_o <= r_mem[w_rd_hash][ctr_width_p-1];
      predict_ghist_o <= r_ghr;
    end else begin
      predict_v_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
module tb_bp_fe_bht_gshare;

  typedef struct packed {
    logic [1:0] ctr;
    logic [5:0] ghist;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       r_v;
  logic [8:0] r_idx;
  logic       p_v, p_taken;
  logic [1:0] p_ctr;
  logic [5:0] p_ghist;
  logic       spec_v, spec_taken;
  logic       w_v;
  logic [8:0] w_idx;
  logic [5:0] w_ghist;
  logic       w_taken;
  logic       rd_v;
  logic [5:0] rd_ghist;
  logic       rd_taken;

  int checks = 0;
  int failures = 0;

  // Reference model
  int   mdl [512];
  logic [5:0] ghr;
  bit   run;
  exp_t sb [$];

  always #5 clk = ~clk;

  bp_fe_bht_gshare dut (
    .clk_i(clk), .reset_n_i(rst_n), .init_done_o(init_done),
    .r_v_i(r_v), .r_idx_i(r_idx),
    .predict_v_o(p_v), .predict_taken_o(p_taken),
    .predict_ctr_o(p_ctr), .predict_ghist_o(p_ghist),
    .spec_v_i(spec_v), .spec_taken_i(spec_taken),
    .w_v_i(w_v), .w_idx_i(w_idx), .w_ghist_i(w_ghist), .w_taken_i(w_taken),
    .redirect_v_i(rd_v), .redirect_ghist_i(rd_ghist),
    .redirect_taken_i(rd_taken)
  );

  task automatic model_init();
    for (int i = 0; i < 512; i++) mdl[i] = 1;
    ghr = '0;
    sb.delete();
  endtask

  // Advance one cycle: record expected prediction, update model, then clear.
  task automatic tick();
    exp_t e;
    int   h;
    if (run && r_v) begin
      h = int'(r_idx ^ {3'b0, ghr});
      e.ctr   = 2'(mdl[h]);
      e.ghist = ghr;
      sb.push_back(e);
    end
    if (run && w_v) begin
      h = int'(w_idx ^ {3'b0, w_ghist});
      if (w_taken) begin if (mdl[h] < 3) mdl[h]++; end
      else         begin if (mdl[h] > 0) mdl[h]--; end
    end
    if (run) begin
      if (rd_v)        ghr = {rd_ghist[4:0], rd_taken};
      else if (spec_v) ghr = {ghr[4:0], spec_taken};
    end
    @(posedge clk); #1;
    r_v = 0; w_v = 0; spec_v = 0; rd_v = 0;
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    int bad = 0;
    r_v = 1; r_idx = 9'h0AA;
    while (!init_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (p_v !== 1'b0) bad++;
    end
    r_v = 0;
    checks++;
    if (n != 512) begin
      failures++;
      $display("FAIL %s_len init cycles got %0d want 512", nm, n);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_quiet predict_v during init got %0d want 0", nm, bad);
    end
    run = 1;
  endtask

  task automatic test_reset();
    r_v = 0; w_v = 0; spec_v = 0; rd_v = 0;
    r_idx = 0; w_idx = 0; w_ghist = 0; w_taken = 0;
    spec_taken = 0; rd_ghist = 0; rd_taken = 0;
    run = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({init_done, p_v, p_taken, p_ctr, p_ghist} !== 11'b0) begin
      failures++;
      $display("FAIL reset_out got %b want 0", {init_done, p_v, p_taken, p_ctr, p_ghist});
    end
    model_init();
    rst_n = 1;
    wait_init("reset");
  endtask

  task automatic test_read_default();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      r_v = 1;
      r_idx = (i == 0) ? 9'h020 : 9'($urandom_range(0, 511));
      tick();
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL rd_default scoreboard empty");
      end else begin
        e = sb.pop_front();
        if ({p_v, p_taken, p_ctr, p_ghist} !== {1'b1, e.ctr[1], e.ctr, e.ghist}
            || p_ctr !== 2'd1) begin
          failures++;
          $display("FAIL rd_default idx=%h got v=%b t=%b c=%0d g=%h want v=1 t=0 c=1 g=%h",
                   r_idx, p_v, p_taken, p_ctr, p_ghist, e.ghist);
        end
      end
    end
  endtask

  task automatic test_saturate();
    int want [7] = '{2, 3, 3, 2, 1, 0, 0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      w_v = 1; w_idx = 9'h005; w_ghist = 0; w_taken = (i < 3);
      tick();
      r_v = 1; r_idx = 9'h005;
      tick();
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL sat_%0d scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (!p_v || p_ctr !== e.ctr || p_ctr !== 2'(want[i]) || p_taken !== e.ctr[1]) begin
          failures++;
          $display("FAIL sat_%0d got v=%b c=%0d t=%b want c=%0d", i, p_v, p_ctr, p_taken, want[i]);
        end
      end
    end
  endtask

  task automatic test_spec();
    exp_t e;
    repeat (3) begin spec_v = 1; spec_taken = 1; tick(); end
    for (int j = 0; j < 3; j++) begin
      if (j == 1) begin
        repeat (2) begin w_v = 1; w_idx = 9'h017; w_ghist = 0; w_taken = 1; tick(); end
      end
      r_v = 1; r_idx = 9'h010;
      if (j == 2) begin spec_v = 1; spec_taken = 0; end  // read sees pre-shift GHR
      tick();
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL spec_%0d scoreboard empty", j);
      end else begin
        e = sb.pop_front();
        if (!p_v || p_ctr !== e.ctr || p_ghist !== e.ghist || p_ghist !== 6'b000111
            || p_ctr !== ((j == 0) ? 2'd1 : 2'd3)) begin
          failures++;
          $display("FAIL spec_%0d got c=%0d g=%b want c=%0d g=000111",
                   j, p_ctr, p_ghist, (j == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    spec_v = 1; spec_taken = 1;
    rd_v = 1; rd_ghist = 6'b101010; rd_taken = 0;
    tick();
    r_v = 1; r_idx = 9'h000;
    tick();
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL redirect scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (!p_v || p_ghist !== 6'b010100 || p_ghist !== e.ghist || p_ctr !== e.ctr) begin
        failures++;
        $display("FAIL redirect got g=%b c=%0d want g=010100 c=%0d", p_ghist, p_ctr, e.ctr);
      end
    end
    rd_v = 1; rd_ghist = 6'b0; rd_taken = 0;
    tick();
    checks++;
    if (p_v !== 1'b0) begin
      failures++; $display("FAIL idle_v got %b want 0", p_v);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      r_v = 1; r_idx = 9'h030;
      if (k == 0) begin w_v = 1; w_idx = 9'h030; w_ghist = 0; w_taken = 1; end
      tick();
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL rw_%0d scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if (!p_v || p_ctr !== e.ctr || p_ctr !== 2'(k + 1)) begin
          failures++;
          $display("FAIL rw_%0d got v=%b c=%0d want c=%0d", k, p_v, p_ctr, k + 1);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [8:0] idxs [3] = '{9'h005, 9'h017, 9'h030};
    spec_v = 1; spec_taken = 1; tick();
    r_v = 1; r_idx = 9'h005;
    rst_n = 0;
    @(posedge clk); #1;
    r_v = 0;
    checks++;
    if ({init_done, p_v, p_ghist} !== 8'b0) begin
      failures++;
      $display("FAIL midrst_out got done=%b v=%b g=%b want 0", init_done, p_v, p_ghist);
    end
    run = 0;
    model_init();
    @(posedge clk); #1;
    rst_n = 1;
    wait_init("midrst");
    for (int i = 0; i < 3; i++) begin
      r_v = 1; r_idx = idxs[i];
      tick();
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL midrst_rd_%0d scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (!p_v || p_ctr !== 2'd1 || p_ctr !== e.ctr || p_ghist !== 6'd0) begin
          failures++;
          $display("FAIL midrst_rd_%0d got c=%0d g=%h want c=1 g=0", i, p_ctr, p_ghist);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_default();
    test_saturate();
    test_spec();
    test_redirect();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
